divider_unit: RTL and testbench

Multi-cycle integer divider for the EX stage of the 5-stage MIPS pipeline. It executes DIV and DIVU, and sits beside the multiplier as a second producer for the HiLo register. It accepts operands from the ID/EX latch on a one-cycle start pulse and iterates one quotient bit per cycle. It then presents a 64-bit {remainder, quotient} word in the same packing the HiLo block already takes from the multiplier: Hi = remainder, Lo = quotient. The hazard unit stalls on `busy`.

---
 rtl/divider_unit_pkg.sv | 26 ++
 rtl/divider_unit.sv | 208 ++++++++++++++++++++
 tb/tb_divider_unit.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_unit_pkg.sv
// -----------------------------------------------------------------------------
// divider_unit_pkg
//
// Purpose : Shared definitions for the EX-stage divider. The HiLo packing
//           constants are shared with the multiplier so both producers agree
//           on where the remainder (Hi) and the quotient (Lo) sit in the
//           64-bit HiLo word.
// Contents: DIV_WIDTH       default operand width
//           HI_MSB / LO_MSB HiLo packing: Hi = [HI_MSB:LO_MSB+1], Lo = [LO_MSB:0]
//           div_state_e     divider FSM state encoding
// -----------------------------------------------------------------------------
package divider_unit_pkg;

   localparam int DIV_WIDTH = 32;

   localparam int HI_MSB = 63;
   localparam int LO_MSB = 31;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

endpackage : divider_unit_pkg

// File: rtl/divider_unit.sv
// -----------------------------------------------------------------------------
// divider_unit
//
// Purpose : Multi-cycle restoring integer divider for DIV / DIVU. Operands are
//           captured on a one-cycle start pulse, one quotient bit is produced
//           per clock, a sign/zero fix-up cycle follows, and the result is
//           presented as {remainder, quotient} for the HiLo register.
//           Latency from the accepting edge to done is WIDTH+1 cycles.
//
// Ports   : clk          clock, rising edge
//           rst          asynchronous active-low reset
//           start        request, sampled only in IDLE or DONE
//           is_signed    1 = DIV, 0 = DIVU (sampled with start)
//           flush        abort the operation in flight; wins over start
//           dataA        dividend (rs)
//           dataB        divisor (rt)
//           busy         high while iterating or fixing up (registered)
//           done         one-cycle pulse when dataOut is updated
//           div_by_zero  last completed operation had a zero divisor
//           dataOut      {remainder, quotient}
// -----------------------------------------------------------------------------
module divider_unit
   import divider_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               is_signed,
   input  logic               flush,
   input  logic [WIDTH-1:0]   dataA,
   input  logic [WIDTH-1:0]   dataB,
   output logic               busy,
   output logic               done,
   output logic               div_by_zero,
   output logic [2*WIDTH-1:0] dataOut
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   div_state_e         state_q,    state_d;
   logic [CNT_W-1:0]   count_q,    count_d;
   logic [WIDTH-1:0]   rem_q,      rem_d;      // partial remainder
   logic [WIDTH-1:0]   quo_q,      quo_d;      // dividend bits out, quotient bits in
   logic [WIDTH-1:0]   divisor_q,  divisor_d;  // |B|
   logic               neg_quo_q,  neg_quo_d;  // sign(A) != sign(B)
   logic               neg_rem_q,  neg_rem_d;  // sign(A)
   logic               zero_q,     zero_d;     // divisor was zero
   logic               busy_q,     busy_d;
   logic               done_q,     done_d;
   logic               dbz_q,      dbz_d;
   logic [2*WIDTH-1:0] data_out_q, data_out_d;

   // ---------------------------------------------------------------------------
   // Datapath helpers
   // ---------------------------------------------------------------------------
   logic [WIDTH:0]   shifted;   // {rem, next dividend bit}
   logic [WIDTH:0]   trial;     // shifted - |B|, bit WIDTH is the borrow
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

   always_comb begin
      a_neg = is_signed & dataA[WIDTH-1];
      b_neg = is_signed & dataB[WIDTH-1];
      a_mag = a_neg ? (-dataA) : dataA;
      b_mag = b_neg ? (-dataB) : dataB;
   end

   // Restoring step. The remainder is always below |B|, so when the trial
   // subtraction borrows the shifted value still fits in WIDTH bits.
   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      trial   = shifted - {1'b0, divisor_q};
   end

   // Sign fix-up. The most negative dividend over -1 naturally wraps back to
   // itself, which is the required quotient, so no special case is needed.
   // A zero divisor keeps the all-ones quotient of the unsigned iteration;
   // its remainder is |A| with the sign of A, i.e. the original dividend.
   always_comb begin
      rem_fix = neg_rem_q ? (-rem_q) : rem_q;
      if (zero_q) begin
         quo_fix = '1;
      end else begin
         quo_fix = neg_quo_q ? (-quo_q) : quo_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      divisor_d  = divisor_q;
      neg_quo_d  = neg_quo_q;
      neg_rem_d  = neg_rem_q;
      zero_d     = zero_q;
      dbz_d      = dbz_q;
      data_out_d = data_out_q;

      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start && !flush) begin
               quo_d     = a_mag;
               divisor_d = b_mag;
               rem_d     = '0;
               neg_quo_d = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               zero_d    = (dataB == '0);
               count_d   = '0;
               state_d   = CALC;
            end
         end

         CALC: begin
            if (flush) begin
               count_d = '0;
               state_d = IDLE;
            end else begin
               if (!trial[WIDTH]) begin
                  rem_d = trial[WIDTH-1:0];
               end else begin
                  rem_d = shifted[WIDTH-1:0];
               end
               quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
               if (count_q == LAST_CNT) begin
                  count_d = '0;
                  state_d = FIX;
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end

         FIX: begin
            if (flush) begin
               state_d = IDLE;
            end else begin
               data_out_d = {rem_fix, quo_fix};
               dbz_d      = zero_q;
               state_d    = DONE;
            end
         end

         default: begin
            state_d = IDLE;
            count_d = '0;
         end
      endcase

      // Flags are decoded from the next state and registered, so busy/done
      // come straight from flops with no decode glitches.
      busy_d = (state_d == CALC) || (state_d == FIX);
      done_d = (state_d == DONE);
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         divisor_q  <= '0;
         neg_quo_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         zero_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         dbz_q      <= 1'b0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         divisor_q  <= divisor_d;
         neg_quo_q  <= neg_quo_d;
         neg_rem_q  <= neg_rem_d;
         zero_q     <= zero_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         dbz_q      <= dbz_d;
         data_out_q <= data_out_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign dataOut     = data_out_q;

endmodule : divider_unit

// File: tb/tb_divider_unit.sv
// -----------------------------------------------------------------------------
// tb_divider_unit
//
// Directed bench for divider_unit. A behavioural model predicts busy, done,
// div_by_zero and dataOut each cycle from the operation timing rules and
// plain 64-bit arithmetic; directed operations additionally pin results,
// latency and busy duration to hand-computed constants.
// -----------------------------------------------------------------------------
module tb_divider_unit;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          is_signed;
   logic          flush;
   logic [W-1:0]  dataA;
   logic [W-1:0]  dataB;
   logic          busy;
   logic          done;
   logic          div_by_zero;
   logic [2*W-1:0] dataOut;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int e0    = 0;

   divider_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .is_signed   (is_signed),
      .flush       (flush),
      .dataA       (dataA),
      .dataB       (dataB),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .dataOut     (dataOut)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------------------
   // Checkers
   // ---------------------------------------------------------------------------
   task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      longint sa;
      longint sb;
      longint q;
      longint r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (s) begin
         sa = {{32{a[31]}}, a};
         sb = {{32{b[31]}}, b};
      end else begin
         sa = {32'd0, a};
         sb = {32'd0, b};
      end
      q = sa / sb;    // truncates toward zero, remainder follows the dividend
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Timing model: an accepted request keeps the unit busy for LAT cycles,
   // then the result appears with a one-cycle done pulse.
   logic        m_busy     = 1'b0;
   logic        m_done     = 1'b0;
   logic        m_dbz      = 1'b0;
   logic [63:0] m_out      = 64'd0;
   logic [63:0] m_pend     = 64'd0;
   logic        m_pend_dbz = 1'b0;
   int          m_left     = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_dbz  = 1'b0;
         m_out  = 64'd0;
         m_left = 0;
      end else begin
         m_done = 1'b0;
         if (m_busy) begin
            if (flush) begin
               m_busy = 1'b0;
               m_left = 0;
            end else begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_busy = 1'b0;
                  m_done = 1'b1;
                  m_out  = m_pend;
                  m_dbz  = m_pend_dbz;
               end
            end
         end else if (start && !flush) begin
            m_pend     = ref_div(dataA, dataB, is_signed);
            m_pend_dbz = (dataB == 32'd0);
            m_busy     = 1'b1;
            m_left     = LAT;
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (cyc > 0) begin
         chk1 ("cyc_busy", busy, m_busy);
         chk1 ("cyc_done", done, m_done);
         chk1 ("cyc_dbz", div_by_zero, m_dbz);
         chk64("cyc_dataOut", dataOut, m_out);
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (called at a negedge)
   // ---------------------------------------------------------------------------
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
      dataA     = a;
      dataB     = b;
      is_signed = s;
      start     = 1'b1;
      e0        = cyc + 1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   task automatic wait_done(input string name, input logic [63:0] exp, input logic exp_dbz,
                            input bit chk_busy);
      int guard;
      int nbusy;
      guard = 0;
      nbusy = 0;
      while (!done && guard < 80) begin
         if (busy) nbusy++;
         @(negedge clk);
         guard++;
      end
      chk1 ({name, "_done_seen"}, done, 1'b1);
      chki ({name, "_latency"}, cyc - e0, LAT);
      chk64({name, "_result"}, dataOut, exp);
      chk1 ({name, "_dbz"}, div_by_zero, exp_dbz);
      if (chk_busy) chki({name, "_busy_cycles"}, nbusy, LAT);
      $display("[TB] %s: A=%h B=%h signed=%0b -> dataOut=%h dbz=%0b", name, dataA, dataB,
               is_signed, dataOut, div_by_zero);
   endtask

   task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic s, input logic [63:0] exp, input logic exp_dbz);
      repeat (2) @(negedge clk);
      issue(a, b, s);
      wait_done(name, exp, exp_dbz, 1'b1);
   endtask

   task automatic expect_no_done(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      chki({name, "_no_done"}, seen, 0);
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      rst       = 1'b0;
      start     = 1'b0;
      is_signed = 1'b0;
      flush     = 1'b0;
      dataA     = '0;
      dataB     = '0;

      // Model pinned against hand-computed values.
      chk64("model_signed_m7_2", ref_div(32'hFFFF_FFF9, 32'h2, 1'b1), 64'hFFFFFFFF_FFFFFFFD);
      chk64("model_minint_m1", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1),
            64'h00000000_80000000);

      repeat (3) @(negedge clk);
      chk1 ("reset_busy", busy, 1'b0);
      chk1 ("reset_done", done, 1'b0);
      chk1 ("reset_dbz", div_by_zero, 1'b0);
      chk64("reset_dataOut", dataOut, 64'd0);
      rst = 1'b1;
      @(negedge clk);

      run("divu_100_7",      32'd100,        32'd7,          1'b0, 64'h00000002_0000000E, 1'b0);
      run("div_m7_2",        32'hFFFF_FFF9,  32'h0000_0002,  1'b1, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
      run("div_minint_m1",   32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 64'h00000000_80000000, 1'b0);
      run("divu_minint_m1",  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 64'h80000000_00000000, 1'b0);
      run("divu_by_zero",    32'h0000_1234,  32'd0,          1'b0, 64'h00001234_FFFFFFFF, 1'b1);
      run("div_by_zero",     32'h0000_1234,  32'd0,          1'b1, 64'h00001234_FFFFFFFF, 1'b1);
      run("divu_10_3",       32'd10,         32'd3,          1'b0, 64'h00000001_00000003, 1'b0);

      // start during an operation is ignored.
      repeat (2) @(negedge clk);
      issue(32'd100, 32'd7, 1'b0);
      repeat (4) @(negedge clk);
      dataA = 32'd999;
      dataB = 32'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dataA = 32'd100;
      dataB = 32'd7;
      wait_done("ignored_start", 64'h00000002_0000000E, 1'b0, 1'b0);

      // Back-to-back: new start in the DONE cycle.
      issue(32'd1000, 32'd10, 1'b0);
      wait_done("back_to_back", 64'h00000000_00000064, 1'b0, 1'b1);

      // Flush mid-CALC.
      repeat (2) @(negedge clk);
      issue(32'd50, 32'd5, 1'b0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk1("flush_busy", busy, 1'b0);
      expect_no_done("flush", 40);
      chk64("flush_keep_dataOut", dataOut, 64'h00000000_00000064);
      $display("[TB] flush: dataOut=%h busy=%0b", dataOut, busy);

      // flush and start together in an accepting cycle: not started.
      dataA = 32'd5;
      dataB = 32'd1;
      start = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      chk1("flush_start_busy", busy, 1'b0);
      expect_no_done("flush_start", 40);
      $display("[TB] flush+start: busy=%0b dataOut=%h", busy, dataOut);

      // Asynchronous reset mid-CALC.
      issue(32'd77, 32'd7, 1'b0);
      repeat (5) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk1 ("arst_busy", busy, 1'b0);
      chk1 ("arst_done", done, 1'b0);
      chk1 ("arst_dbz", div_by_zero, 1'b0);
      chk64("arst_dataOut", dataOut, 64'd0);
      $display("[TB] async reset: busy=%0b done=%0b dataOut=%h", busy, done, dataOut);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run("after_reset_100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 1'b0);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_divider_unit
